// File: rtl/ddr4_request_queue_if.sv
// Request/response bundle between the trace reader, the request queue and the DDR4 controller.
// Defining IQ_STATS_EN adds the max_count and drop_count statistics signals.
interface ddr4_request_queue_if #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 36,
    parameter int TIME_W = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [TIME_W-1:0] time_in;
    logic [31:0]       operation_in;
    logic [ADDR_W-1:0] address_in;
    logic              valid;
    logic              done;
    logic              full;
    logic              empty;
    logic [CW-1:0]     count;
    logic [TIME_W-1:0] cur_time;
    logic              out_valid;
    logic              out_ready;
    logic [TIME_W-1:0] out_time;
    logic [1:0]        out_op;
    logic [ADDR_W-1:0] out_addr;
    logic [15:0]       out_row;
    logic [7:0]        out_col;
    logic [1:0]        out_bank;
    logic [1:0]        out_bg;
    logic              bad_op;
    logic              all_done;
`ifdef IQ_STATS_EN
    logic [CW-1:0]     max_count;
    logic [15:0]       drop_count;
`endif

    modport slave (
        input  time_in, operation_in, address_in, valid, done, out_ready,
        output full, empty, count, cur_time, out_valid, out_time, out_op,
        output out_addr, out_row, out_col, out_bank, out_bg, bad_op, all_done
`ifdef IQ_STATS_EN
        , output max_count, drop_count
`endif
    );

    modport master (
        output time_in, operation_in, address_in, valid, done, out_ready,
        input  full, empty, count, cur_time, out_valid, out_time, out_op,
        input  out_addr, out_row, out_col, out_bank, out_bg, bad_op, all_done
`ifdef IQ_STATS_EN
        , input max_count, drop_count
`endif
    );
endinterface

// File: rtl/ddr4_request_queue.sv
// In-order DDR4 request FIFO with head address decode, cycle counter and drain detection.
// Optional statistics (max occupancy, saturating drop count) are built when IQ_STATS_EN is defined.
module ddr4_request_queue #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 36,
    parameter int TIME_W = 32
) (
    input logic clock,
    input logic reset,
    ddr4_request_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [TIME_W-1:0] r_time_mem [DEPTH];
    logic [1:0]        r_op_mem   [DEPTH];
    logic [ADDR_W-1:0] r_addr_mem [DEPTH];

    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic [TIME_W-1:0] r_cur_time;
    logic              r_bad_op;
    logic              r_done_seen;

    logic              w_full;
    logic              w_empty;
    logic              w_op_legal;
    logic              w_enq;
    logic              w_deq;
    logic              w_bad_evt;
    logic [CW-1:0]     w_count_nxt;
    logic [ADDR_W-1:0] w_head_addr;

    // Handshake qualification; full is taken from the current count so a dequeue cannot open a slot the same cycle.
    always_comb begin
        w_full      = (r_count == CW'(DEPTH));
        w_empty     = (r_count == {CW{1'b0}});
        w_op_legal  = (bus.operation_in <= 32'd2);
        w_enq       = bus.valid && !w_full && w_op_legal;
        w_deq       = !w_empty && bus.out_ready;
        w_bad_evt   = bus.valid && !w_op_legal;
        w_count_nxt = r_count;
        case ({w_enq, w_deq})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Pointers, occupancy, cycle counter, error pulse and done latch.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr    <= {PW{1'b0}};
            r_rd_ptr    <= {PW{1'b0}};
            r_count     <= {CW{1'b0}};
            r_cur_time  <= {TIME_W{1'b0}};
            r_bad_op    <= 1'b0;
            r_done_seen <= 1'b0;
        end else begin
            r_cur_time <= r_cur_time + TIME_W'(1);
            r_count    <= w_count_nxt;
            r_bad_op   <= w_bad_evt;
            if (w_enq) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (bus.done) begin
                r_done_seen <= 1'b1;
            end
        end
    end

    // Entry storage; contents need no reset because count gates visibility.
    always_ff @(posedge clock) begin
        if (w_enq) begin
            r_time_mem[r_wr_ptr] <= bus.time_in;
            r_op_mem[r_wr_ptr]   <= bus.operation_in[1:0];
            r_addr_mem[r_wr_ptr] <= bus.address_in;
        end
    end

    assign w_head_addr   = r_addr_mem[r_rd_ptr];

    assign bus.full      = w_full;
    assign bus.empty     = w_empty;
    assign bus.count     = r_count;
    assign bus.cur_time  = r_cur_time;
    assign bus.out_valid = !w_empty;
    assign bus.out_time  = r_time_mem[r_rd_ptr];
    assign bus.out_op    = r_op_mem[r_rd_ptr];
    assign bus.out_addr  = w_head_addr;
    assign bus.out_row   = w_head_addr[33:18];
    assign bus.out_col   = w_head_addr[17:10];
    assign bus.out_bank  = w_head_addr[9:8];
    assign bus.out_bg    = w_head_addr[7:6];
    assign bus.bad_op    = r_bad_op;
    assign bus.all_done  = r_done_seen && w_empty;

`ifdef IQ_STATS_EN
    logic [CW-1:0] r_max_count;
    logic [15:0]   r_drop_count;

    // High-water mark and saturating count of dropped illegal requests.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_max_count  <= {CW{1'b0}};
            r_drop_count <= 16'd0;
        end else begin
            if (w_count_nxt > r_max_count) begin
                r_max_count <= w_count_nxt;
            end
            if (w_bad_evt && (r_drop_count != 16'hFFFF)) begin
                r_drop_count <= r_drop_count + 16'd1;
            end
        end
    end

    assign bus.max_count  = r_max_count;
    assign bus.drop_count = r_drop_count;
`endif
endmodule

// File: tb/tb_ddr4_request_queue.sv
// Directed self-checking bench for ddr4_request_queue; expected values are hand-derived.
module tb_ddr4_request_queue;
    logic clock;
    logic reset;
    int   checks;
    int   failures;

    ddr4_request_queue_if #(.DEPTH(16), .ADDR_W(36), .TIME_W(32)) bus ();

    ddr4_request_queue #(.DEPTH(16), .ADDR_W(36), .TIME_W(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [35:0] a;
        checks   = 0;
        failures = 0;
        reset            = 1'b1;
        bus.time_in      = 32'd0;
        bus.operation_in = 32'd0;
        bus.address_in   = 36'd0;
        bus.valid        = 1'b0;
        bus.done         = 1'b0;
        bus.out_ready    = 1'b0;
        step();
        step();
        reset = 1'b0;

        // Reset state after 5 idle cycles
        for (int i = 0; i < 5; i++) step();
        check("rst_empty", 64'(bus.empty), 64'd1);
        check("rst_full", 64'(bus.full), 64'd0);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_count", 64'(bus.count), 64'd0);
        check("rst_cur_time", 64'(bus.cur_time), 64'd5);
        check("rst_bad_op", 64'(bus.bad_op), 64'd0);
        check("rst_all_done", 64'(bus.all_done), 64'd0);

        // Single enqueue and head decode
        bus.valid        = 1'b1;
        bus.time_in      = 32'd10;
        bus.operation_in = 32'd1;
        bus.address_in   = 36'h0_0004_C1C0;
        step();
        bus.valid = 1'b0;
        check("one_out_valid", 64'(bus.out_valid), 64'd1);
        check("one_count", 64'(bus.count), 64'd1);
        check("one_time", 64'(bus.out_time), 64'd10);
        check("one_op", 64'(bus.out_op), 64'd1);
        check("one_addr", 64'(bus.out_addr), 64'h4C1C0);
        check("one_row", 64'(bus.out_row), 64'h0001);
        check("one_col", 64'(bus.out_col), 64'h30);
        check("one_bank", 64'(bus.out_bank), 64'd1);
        check("one_bg", 64'(bus.out_bg), 64'd3);
        step();
        check("one_hold_time", 64'(bus.out_time), 64'd10);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check("one_drained", 64'(bus.empty), 64'd1);

        // Fill 16 entries: row = index, op = index mod 3
        bus.valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.time_in      = 32'(100 + i);
            bus.operation_in = 32'(i % 3);
            a                = 36'(i);
            bus.address_in   = a << 18;
            step();
        end
        check("fill_full", 64'(bus.full), 64'd1);
        check("fill_count", 64'(bus.count), 64'd16);
        check("fill_empty", 64'(bus.empty), 64'd0);

        // 17th request while full is ignored without error
        bus.time_in      = 32'd200;
        bus.operation_in = 32'd2;
        bus.address_in   = 36'h0_0000_0040;
        step();
        check("full_ignore_count", 64'(bus.count), 64'd16);
        check("full_ignore_bad_op", 64'(bus.bad_op), 64'd0);
        check("full_head_time", 64'(bus.out_time), 64'd100);

        // Valid and ready together at full: only the dequeue happens
        bus.out_ready = 1'b1;
        step();
        check("full_simul_count", 64'(bus.count), 64'd15);
        check("full_simul_head", 64'(bus.out_time), 64'd101);
        bus.out_ready = 1'b0;
        step();
        bus.valid = 1'b0;
        check("refill_count", 64'(bus.count), 64'd16);

        // Drain in order
        bus.out_ready = 1'b1;
        for (int i = 1; i < 16; i++) begin
            check("drain_time", 64'(bus.out_time), 64'(100 + i));
            check("drain_op", 64'(bus.out_op), 64'(i % 3));
            check("drain_row", 64'(bus.out_row), 64'(i));
            step();
        end
        check("drain_last_time", 64'(bus.out_time), 64'd200);
        check("drain_last_op", 64'(bus.out_op), 64'd2);
        check("drain_last_bg", 64'(bus.out_bg), 64'd1);
        step();
        check("drain_empty", 64'(bus.empty), 64'd1);
        check("drain_count", 64'(bus.count), 64'd0);
        step();
        check("ready_empty_count", 64'(bus.count), 64'd0);
        bus.out_ready = 1'b0;

        // Illegal operation
        bus.valid        = 1'b1;
        bus.operation_in = 32'd3;
        bus.time_in      = 32'd250;
        step();
        bus.valid = 1'b0;
        check("bad_op_pulse", 64'(bus.bad_op), 64'd1);
        check("bad_op_count", 64'(bus.count), 64'd0);
        step();
        check("bad_op_clear", 64'(bus.bad_op), 64'd0);
`ifdef IQ_STATS_EN
        check("stats_drop", 64'(bus.drop_count), 64'd1);
        check("stats_max", 64'(bus.max_count), 64'd16);
`endif

        // Done with two entries queued
        bus.valid        = 1'b1;
        bus.operation_in = 32'd0;
        bus.time_in      = 32'd300;
        step();
        bus.time_in = 32'd301;
        step();
        bus.valid = 1'b0;
        bus.done  = 1'b1;
        step();
        check("done_q2_all_done", 64'(bus.all_done), 64'd0);
        check("done_q2_count", 64'(bus.count), 64'd2);
        bus.out_ready = 1'b1;
        step();
        check("done_q1_all_done", 64'(bus.all_done), 64'd0);
        step();
        check("done_q0_all_done", 64'(bus.all_done), 64'd1);
        bus.out_ready = 1'b0;
        bus.done      = 1'b0;
        step();
        check("done_sticky", 64'(bus.all_done), 64'd1);

        // Reset mid-stream
        bus.valid        = 1'b1;
        bus.operation_in = 32'd2;
        bus.time_in      = 32'd400;
        step();
        bus.valid = 1'b0;
        check("pre_reset_count", 64'(bus.count), 64'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_rst_all_done", 64'(bus.all_done), 64'd0);
        check("mid_rst_empty", 64'(bus.empty), 64'd1);
        check("mid_rst_count", 64'(bus.count), 64'd0);
        check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("mid_rst_cur_time", 64'(bus.cur_time), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
